// File: rtl/pill_feeder.sv
// ---------------------------------------------------------------------------
// pill_feeder -- batch pill dispenser controller.
//
// A batch fills `nbottles` bottles with `pillc` pills each. Between pill
// pulses within one bottle, `gap` idle cycles are inserted. After every
// bottle the conveyor is advanced by one position. The batch parameters are
// captured when the batch starts, so later input changes do not disturb a
// running batch.
//
// Ports:
//   clk            in   clock, all state changes on the rising edge
//   rst            in   synchronous active-high reset
//   start          in   begin a batch (looked at only while idle)
//   pillc[5:0]     in   pills per bottle
//   nbottles[7:0]  in   bottles per batch
//   gap[3:0]       in   idle cycles between pills of one bottle
//   bottle_rdy     in   empty bottle in place under the chute
//   abort          in   cancel the running batch (counters keep their values)
//   pill           out  one-cycle pulse per dropped pill
//   conv           out  one-cycle pulse to advance the conveyor
//   busy           out  high whenever a batch is in progress
//   done           out  one-cycle pulse on normal batch completion
//   bottles_filled out  bottles completed in the current/last batch
//   pills_total    out  pills dropped in the current/last batch (saturating)
//
// The pulse outputs are Moore outputs of the state: they are registered from
// the next-state value, so each one is high exactly while the state register
// holds the matching state.
// ---------------------------------------------------------------------------
module pill_feeder (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  pillc,
    input  logic [7:0]  nbottles,
    input  logic [3:0]  gap,
    input  logic        bottle_rdy,
    input  logic        abort,
    output logic        pill,
    output logic        conv,
    output logic        busy,
    output logic        done,
    output logic [7:0]  bottles_filled,
    output logic [15:0] pills_total
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        WAIT_BOTTLE = 3'd1,
        DROP        = 3'd2,
        GAP         = 3'd3,
        ADVANCE     = 3'd4,
        DONE        = 3'd5
    } state_t;

    state_t      state_r;
    state_t      next_state_s;

    logic [5:0]  pillc_r;
    logic [7:0]  nbottles_r;
    logic [3:0]  gap_r;
    logic [5:0]  pill_cnt_r;
    logic [3:0]  gap_cnt_r;
    logic [7:0]  bottles_r;
    logic [15:0] total_r;
    logic        pill_r;
    logic        conv_r;
    logic        busy_r;
    logic        done_r;

    // Increment that sticks at the top value instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    // Next-state decision; abort overrides every other transition.
    always_comb begin
        next_state_s = state_r;
        if ((state_r != IDLE) && abort) begin
            next_state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        // Parameters are latched on this same edge, so the
                        // live inputs decide the empty-batch shortcut.
                        if ((pillc == 6'd0) || (nbottles == 8'd0)) begin
                            next_state_s = DONE;
                        end else begin
                            next_state_s = WAIT_BOTTLE;
                        end
                    end else begin
                        next_state_s = IDLE;
                    end
                end
                WAIT_BOTTLE: begin
                    if (bottle_rdy) begin
                        next_state_s = DROP;
                    end else begin
                        next_state_s = WAIT_BOTTLE;
                    end
                end
                DROP: begin
                    if ((pill_cnt_r + 6'd1) == pillc_r) begin
                        next_state_s = ADVANCE;
                    end else if (gap_r == 4'd0) begin
                        next_state_s = DROP;
                    end else begin
                        next_state_s = GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt_r == 4'd1) begin
                        next_state_s = DROP;
                    end else begin
                        next_state_s = GAP;
                    end
                end
                ADVANCE: begin
                    if ((bottles_r + 8'd1) == nbottles_r) begin
                        next_state_s = DONE;
                    end else begin
                        next_state_s = WAIT_BOTTLE;
                    end
                end
                DONE: begin
                    next_state_s = IDLE;
                end
                default: begin
                    next_state_s = IDLE;
                end
            endcase
        end
    end

    // State register, registered Moore outputs, latched parameters and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            pillc_r    <= 6'd0;
            nbottles_r <= 8'd0;
            gap_r      <= 4'd0;
            pill_cnt_r <= 6'd0;
            gap_cnt_r  <= 4'd0;
            bottles_r  <= 8'd0;
            total_r    <= 16'd0;
            pill_r     <= 1'b0;
            conv_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r <= next_state_s;
            pill_r  <= (next_state_s == DROP);
            conv_r  <= (next_state_s == ADVANCE);
            busy_r  <= (next_state_s != IDLE);
            done_r  <= (next_state_s == DONE);

            if (state_r == IDLE) begin
                if (start) begin
                    pillc_r    <= pillc;
                    nbottles_r <= nbottles;
                    gap_r      <= gap;
                    pill_cnt_r <= 6'd0;
                    gap_cnt_r  <= 4'd0;
                    bottles_r  <= 8'd0;
                    total_r    <= 16'd0;
                end else begin
                    pill_cnt_r <= pill_cnt_r;
                end
            end else if (!abort) begin
                case (state_r)
                    DROP: begin
                        pill_cnt_r <= pill_cnt_r + 6'd1;
                        total_r    <= sat_inc16(total_r);
                        if (next_state_s == GAP) begin
                            gap_cnt_r <= gap_r;
                        end else begin
                            gap_cnt_r <= gap_cnt_r;
                        end
                    end
                    GAP: begin
                        gap_cnt_r <= gap_cnt_r - 4'd1;
                    end
                    ADVANCE: begin
                        bottles_r  <= bottles_r + 8'd1;
                        pill_cnt_r <= 6'd0;
                    end
                    default: begin
                        pill_cnt_r <= pill_cnt_r;
                    end
                endcase
            end else begin
                // Aborted: counters freeze at their current values.
                pill_cnt_r <= pill_cnt_r;
            end
        end
    end

    assign pill           = pill_r;
    assign conv           = conv_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign bottles_filled = bottles_r;
    assign pills_total    = total_r;

endmodule

// ---------------------------------------------------------------------------
// pill_feeder_chk -- protocol properties of the pill_feeder outputs.
//
// Ports: clk, rst, and the pill/conv/done/busy outputs being observed.
// ---------------------------------------------------------------------------
module pill_feeder_chk (
    input logic clk,
    input logic rst,
    input logic pill,
    input logic conv,
    input logic done,
    input logic busy
);

    // A pill and a conveyor step never happen together.
    property p_pill_conv_excl;
        @(posedge clk) disable iff (rst) !(pill && conv);
    endproperty
    a_pill_conv_excl: assert property (p_pill_conv_excl);

    // done lasts a single cycle and only occurs while busy.
    property p_done_pulse;
        @(posedge clk) disable iff (rst) done |-> (busy ##1 !done);
    endproperty
    a_done_pulse: assert property (p_done_pulse);

endmodule

// File: tb/tb_pill_feeder.sv
// ---------------------------------------------------------------------------
// tb_pill_feeder -- scoreboard bench for pill_feeder.
// Stimulus pushes the expected pulse sequence (kind + cycle number, plus the
// counter values expected at done); a negedge monitor pops and compares
// whenever pill, conv or done is high.
// ---------------------------------------------------------------------------
module tb_pill_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  pillc;
    logic [7:0]  nbottles;
    logic [3:0]  gap;
    logic        bottle_rdy;
    logic        abort;
    logic        pill;
    logic        conv;
    logic        busy;
    logic        done;
    logic [7:0]  bottles_filled;
    logic [15:0] pills_total;

    pill_feeder dut (
        .clk(clk), .rst(rst), .start(start), .pillc(pillc),
        .nbottles(nbottles), .gap(gap), .bottle_rdy(bottle_rdy),
        .abort(abort), .pill(pill), .conv(conv), .busy(busy), .done(done),
        .bottles_filled(bottles_filled), .pills_total(pills_total)
    );

    pill_feeder_chk u_chk (
        .clk(clk), .rst(rst), .pill(pill), .conv(conv), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam int K_PILL = 0;
    localparam int K_CONV = 1;
    localparam int K_DONE = 2;

    typedef struct {
        int kind;
        int cyc;
        int bf;
        int pt;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act == req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push_ev(input int kind, input int c, input int bf, input int pt);
        ev_t e;
        e.kind = kind; e.cyc = c; e.bf = bf; e.pt = pt;
        exp_q.push_back(e);
    endtask

    // Expected pulses of a full batch with bottle_rdy held high; d is the
    // cycle of the first pill.
    task automatic push_batch(input int p, input int nb, input int g, input int d,
                              input int bf, input int pt);
        int first;
        int last;
        first = d;
        last  = d;
        for (int b = 0; b < nb; b++) begin
            for (int k = 0; k < p; k++) begin
                push_ev(K_PILL, first + k * (g + 1), 0, 0);
            end
            last = first + (p - 1) * (g + 1);
            push_ev(K_CONV, last + 1, 0, 0);
            first = last + 3;
        end
        push_ev(K_DONE, last + 2, bf, pt);
    endtask

    // Monitor: every output pulse must match the head of the queue.
    always @(negedge clk) begin
        ev_t e;
        int  kind_s;
        if (pill || conv || done) begin
            kind_s = pill ? K_PILL : (conv ? K_CONV : K_DONE);
            if (pill && conv) check("pill_conv_excl", 1, 0);
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_pulse: got kind %0d at cycle %0d, expected none",
                         kind_s, cyc);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind", kind_s, e.kind);
                check("pulse_cycle", cyc, e.cyc);
                if (e.kind == K_DONE) begin
                    check("done_bottles_filled", bottles_filled, e.bf);
                    check("done_pills_total", pills_total, e.pt);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive start for one sampling edge; c0 is the cycle right after it.
    task automatic do_start(input logic [5:0] p, input logic [7:0] nb,
                            input logic [3:0] g, output int c0);
        pillc    = p;
        nbottles = nb;
        gap      = g;
        start    = 1'b1;
        c0       = cyc + 1;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int bound);
        int n;
        n = 0;
        while (((exp_q.size() != 0) || busy) && (n < bound)) begin
            tick();
            n++;
        end
        check(name, ((exp_q.size() == 0) && !busy) ? 1 : 0, 1);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_pill"}, pill, 0);
        check({name, "_conv"}, conv, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_done"}, done, 0);
        check({name, "_bottles_filled"}, bottles_filled, 0);
        check({name, "_pills_total"}, pills_total, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int d;
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        bottle_rdy = 1'b0;
        pillc      = 6'd0;
        nbottles   = 8'd0;
        gap        = 4'd0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // 3 pills x 2 bottles, back-to-back pills.
        bottle_rdy = 1'b1;
        do_start(6'd3, 8'd2, 4'd0, c0);
        push_batch(3, 2, 0, c0 + 1, 2, 6);
        wait_drain("b3x2_drained", 100);
        repeat (3) tick();
        check("b3x2_bf_held", bottles_filled, 2);
        check("b3x2_pt_held", pills_total, 6);

        // gap=2: pills 3 cycles apart; input changes and start while busy ignored.
        do_start(6'd2, 8'd1, 4'd2, c0);
        push_batch(2, 1, 2, c0 + 1, 1, 2);
        pillc    = 6'd7;
        gap      = 4'd0;
        nbottles = 8'd9;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        wait_drain("gap2_drained", 100);

        // bottle_rdy low for 10 cycles after start.
        bottle_rdy = 1'b0;
        do_start(6'd1, 8'd1, 4'd0, c0);
        repeat (10) tick();
        check("rdy_wait_busy", busy, 1);
        check("rdy_wait_no_pill", pills_total, 0);
        bottle_rdy = 1'b1;
        push_batch(1, 1, 0, c0 + 11, 1, 1);
        wait_drain("rdy_drained", 100);

        // Empty batches: done one cycle after start, counters 0.
        do_start(6'd0, 8'd5, 4'd3, c0);
        push_ev(K_DONE, c0, 0, 0);
        wait_drain("pillc0_drained", 20);
        do_start(6'd4, 8'd0, 4'd0, c0);
        push_ev(K_DONE, c0, 0, 0);
        wait_drain("nb0_drained", 20);

        // Abort in the gap after the 4th of 5 pills.
        do_start(6'd5, 8'd1, 4'd3, c0);
        d = c0 + 1;
        for (int k = 0; k < 4; k++) push_ev(K_PILL, d + 4 * k, 0, 0);
        while (cyc < d + 13) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_pt", pills_total, 4);
        check("abort_bf", bottles_filled, 0);
        repeat (5) tick();
        check("abort_pt_held", pills_total, 4);
        check("abort_queue_empty", exp_q.size(), 0);

        // Largest batch: 63 x 255 pills.
        do_start(6'd63, 8'd255, 4'd0, c0);
        push_batch(63, 255, 0, c0 + 1, 255, 16065);
        wait_drain("big_drained", 20000);
        check("big_pt_held", pills_total, 16065);

        // Reset in the middle of a batch.
        do_start(6'd63, 8'd255, 4'd0, c0);
        for (int k = 1; k <= 30; k++) push_ev(K_PILL, c0 + k, 0, 0);
        while (cyc < c0 + 30) tick();
        rst = 1'b1;
        tick();
        check_all_zero("midrst");
        rst = 1'b0;
        repeat (3) tick();
        check("midrst_queue_empty", exp_q.size(), 0);
        check("midrst_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
